traffic_monitor: RTL and testbench
==================================

# traffic_monitor

Independent conflict/sequence monitor that observes the six lamp outputs of the intersection controller, the receiving end of its lamp interface, and latches a fault when the observed signals are unsafe or out of sequence. It sits beside the controller, samples its registered lamp outputs every clock, and drives a sticky fault plus a 3-bit cause code for the flash/override logic.

## Interface
- MIN_GREEN, 30: minimum green dwell, in samples
- MIN_YELLOW, 3: minimum yellow dwell, in samples
- MIN_CLEAR, 4: minimum consecutive all-red samples before either direction turns green
- MAX_HOLD, 100: samples with no lamp change that count as stuck; must be 2..255
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ns_green, ns_yellow, ns_red  in  1 each  observed north-south lamps
- ew_green, ew_yellow, ew_red  in  1 each  observed east-west lamps
- fault_clr  in  1  synchronous single-cycle fault release
- armed  out  1  sequence/duration checks active
- fault  out  1  sticky fault flag
- fault_code  out  3  cause of the latched fault; 0 when no fault is latched

## Operation
- Every posedge samples the six lamp inputs. The previous sample is held in a register, prev. The reset value of prev is all-red.
- Per-direction lamp state is decoded as G, Y, R, or BAD. BAD means the lamp bits are not one-hot.
- Codes and checks, with the lowest code winning when several fire in the same cycle:
  - 1 CONFLICT: both directions non-red in the same sample.
  - 2 ENCODING: either direction is BAD.
  - 3 SEQUENCE: a direction changes other than G->Y, Y->R or R->G.
  - 4 SHORT_GREEN: G->Y occurs with that direction's dwell < MIN_GREEN.
  - 5 SHORT_YELLOW: Y->R occurs with dwell < MIN_YELLOW.
  - 6 SHORT_CLEAR: R->G occurs with the all-red counter < MIN_CLEAR.
  - 7 STUCK: the unchanged counter reaches MAX_HOLD.
- Codes 1-2 are checked at all times after reset. Codes 3-7 are checked only while armed=1.
- Counters are 8-bit and saturate at 255.
  - Dwell counter, one per direction: reset to 1 when that direction's state changes, otherwise +1.
  - All-red counter: consecutive samples with both directions R; reset to 0 on any non-all-red sample.
  - Unchanged counter: consecutive samples with all six inputs equal to prev; reset to 0 on any change.
- Arming:
  - armed goes 0->1 on the first all-red sample while disarmed with fault=0.
  - On that edge both dwell counters and the unchanged counter restart at 1. The all-red counter is unaffected.
- Fault latch:
  - The first detected violation sets fault=1 and captures fault_code.
  - Further violations do not change the code.
  - Any fault forces armed=0.
- fault_clr:
  - Clears fault, fault_code and armed.
  - Re-arming follows the normal arming rule.
  - If a code 1 or 2 violation is sampled in the same cycle as fault_clr, the new fault wins: fault stays 1 and fault_code takes the new code.
  - fault_clr with fault=0 only disarms.
- Asynchronous reset mid-operation immediately returns every register to its reset value.

## Timing
- Reset values: armed=0, fault=0, fault_code=0, all counters 0, prev all-red.
- One-cycle latency: a violating value sampled at posedge k gives fault=1 and a valid code after posedge k (registered output). There is no combinational path from inputs to outputs.
- armed rises after the posedge that samples the first qualifying all-red.
- Durations are measured in samples. A yellow present for exactly MIN_YELLOW samples passes; MIN_YELLOW-1 samples fails.
- STUCK fires on the posedge where the unchanged count becomes MAX_HOLD. An input change on that same posedge prevents it.

## Test plan
- Legal cycle with green=60, yellow=4, all-red=7 per direction, repeated 3 full cycles -> armed=1 after the first sample, fault stays 0.
- ns_green=1 and ew_yellow=1 for one sample while disarmed -> fault=1, fault_code=1 one cycle later, armed=0.
- Armed, NS yellow held 2 samples then red (MIN_YELLOW=3) -> fault_code=5. A second violation afterwards leaves the code at 5.
- Armed, NS goes G->R directly -> code 3. Same cycle, also set ns_yellow with ns_red -> code 2 wins.
- Armed, all-red held 3 samples then EW green -> code 6. Pulse fault_clr -> fault=0, armed=0. Then an all-red sample -> armed=1.
- Armed, inputs frozen at NS green (MAX_HOLD=100) -> fault_code=7 exactly after the 100th unchanged sample. Assert resetn low mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_monitor.sv
// Independent safety monitor for the intersection lamp outputs: flags conflicts,
// bad encodings, illegal sequences, short phases and stuck lamps with a sticky fault.
module traffic_monitor #(
    parameter int MIN_GREEN  = 30,
    parameter int MIN_YELLOW = 3,
    parameter int MIN_CLEAR  = 4,
    parameter int MAX_HOLD   = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ns_green,
    input  logic       ns_yellow,
    input  logic       ns_red,
    input  logic       ew_green,
    input  logic       ew_yellow,
    input  logic       ew_red,
    input  logic       fault_clr,
    output logic       armed,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic [1:0] {
        LAMP_G   = 2'd0,
        LAMP_Y   = 2'd1,
        LAMP_R   = 2'd2,
        LAMP_BAD = 2'd3
    } lamp_t;

    localparam logic [7:0] MIN_GREEN_C  = 8'(MIN_GREEN);
    localparam logic [7:0] MIN_YELLOW_C = 8'(MIN_YELLOW);
    localparam logic [7:0] MIN_CLEAR_C  = 8'(MIN_CLEAR);
    localparam logic [7:0] MAX_HOLD_C   = 8'(MAX_HOLD);
    localparam logic [5:0] ALL_RED      = 6'b001_001;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_ENCODING = 3'd2;
    localparam logic [2:0] CODE_SEQUENCE = 3'd3;
    localparam logic [2:0] CODE_SHORT_G  = 3'd4;
    localparam logic [2:0] CODE_SHORT_Y  = 3'd5;
    localparam logic [2:0] CODE_SHORT_C  = 3'd6;
    localparam logic [2:0] CODE_STUCK    = 3'd7;

    logic [5:0] cur;
    logic [5:0] prev;
    logic [7:0] ns_dwell;
    logic [7:0] ew_dwell;
    logic [7:0] clear_cnt;
    logic [7:0] unch_cnt;

    lamp_t      ns_now;
    lamp_t      ew_now;
    lamp_t      ns_prev;
    lamp_t      ew_prev;
    logic       all_red_now;
    logic       unchanged;
    logic [7:0] unch_next;
    logic [2:0] ns_step;
    logic [2:0] ew_step;
    logic [2:0] viol;

    function automatic lamp_t decode(input logic [2:0] gyr);
        lamp_t st;
        case (gyr)
            3'b100:  st = LAMP_G;
            3'b010:  st = LAMP_Y;
            3'b001:  st = LAMP_R;
            default: st = LAMP_BAD;
        endcase
        return st;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classifies one direction's state change; dwell/clear are the counts accumulated before this sample.
    function automatic logic [2:0] step_code(input lamp_t from, input lamp_t to,
                                             input logic [7:0] dwell, input logic [7:0] clear);
        logic [2:0] code;
        code = CODE_NONE;
        if (from != to) begin
            if (from == LAMP_G && to == LAMP_Y)
                code = (dwell < MIN_GREEN_C) ? CODE_SHORT_G : CODE_NONE;
            else if (from == LAMP_Y && to == LAMP_R)
                code = (dwell < MIN_YELLOW_C) ? CODE_SHORT_Y : CODE_NONE;
            else if (from == LAMP_R && to == LAMP_G)
                code = (clear < MIN_CLEAR_C) ? CODE_SHORT_C : CODE_NONE;
            else
                code = CODE_SEQUENCE;
        end
        return code;
    endfunction

    function automatic logic [2:0] lowest(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        if (a == CODE_NONE)
            r = b;
        else if (b == CODE_NONE)
            r = a;
        else
            r = (a < b) ? a : b;
        return r;
    endfunction

    assign cur = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};

    always_comb begin
        ns_now      = decode(cur[5:3]);
        ew_now      = decode(cur[2:0]);
        ns_prev     = decode(prev[5:3]);
        ew_prev     = decode(prev[2:0]);
        all_red_now = (cur == ALL_RED);
        unchanged   = (cur == prev);
        unch_next   = unchanged ? sat_inc(unch_cnt) : 8'd0;
        ns_step     = step_code(ns_prev, ns_now, ns_dwell, clear_cnt);
        ew_step     = step_code(ew_prev, ew_now, ew_dwell, clear_cnt);
        viol        = CODE_NONE;
        // Safety checks always run; sequence and timing checks need a known-good starting point.
        if (ns_now != LAMP_R && ew_now != LAMP_R)
            viol = CODE_CONFLICT;
        else if (ns_now == LAMP_BAD || ew_now == LAMP_BAD)
            viol = CODE_ENCODING;
        else if (armed)
            viol = lowest(lowest(ns_step, ew_step),
                          (unchanged && unch_next == MAX_HOLD_C) ? CODE_STUCK : CODE_NONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev       <= ALL_RED;
            ns_dwell   <= 8'd0;
            ew_dwell   <= 8'd0;
            clear_cnt  <= 8'd0;
            unch_cnt   <= 8'd0;
            armed      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            prev      <= cur;
            ns_dwell  <= (ns_now != ns_prev) ? 8'd1 : sat_inc(ns_dwell);
            ew_dwell  <= (ew_now != ew_prev) ? 8'd1 : sat_inc(ew_dwell);
            clear_cnt <= all_red_now ? sat_inc(clear_cnt) : 8'd0;
            unch_cnt  <= unch_next;

            if (fault_clr) begin
                // A fresh safety violation in the release cycle must not be lost.
                armed <= 1'b0;
                if (viol == CODE_CONFLICT || viol == CODE_ENCODING) begin
                    fault      <= 1'b1;
                    fault_code <= viol;
                end else begin
                    fault      <= 1'b0;
                    fault_code <= CODE_NONE;
                end
            end else if (!fault && viol != CODE_NONE) begin
                fault      <= 1'b1;
                fault_code <= viol;
                armed      <= 1'b0;
            end else if (!fault && !armed && all_red_now) begin
                armed    <= 1'b1;
                ns_dwell <= 8'd1;
                ew_dwell <= 8'd1;
                unch_cnt <= 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: directed scenarios plus randomized lamp
// sequences, compared every cycle against a history-based reference model.
module tb_traffic_monitor;

    localparam int MIN_GREEN  = 30;
    localparam int MIN_YELLOW = 3;
    localparam int MIN_CLEAR  = 4;
    localparam int MAX_HOLD   = 100;

    localparam logic [5:0] ALLRED = 6'b001_001;
    localparam logic [5:0] NSG    = 6'b100_001;
    localparam logic [5:0] NSY    = 6'b010_001;
    localparam logic [5:0] EWG    = 6'b001_100;
    localparam logic [5:0] EWY    = 6'b001_010;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fault_clr = 1'b0;
    logic [5:0] lamps = ALLRED;
    logic       armed;
    logic       fault;
    logic [2:0] fault_code;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: full sample history since reset, plus the index of the latest arming sample.
    logic [5:0] hist[$];
    int         arm_idx;
    logic       m_armed;
    logic       m_fault;
    logic [2:0] m_code;

    traffic_monitor #(
        .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW),
        .MIN_CLEAR(MIN_CLEAR), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ns_green(lamps[5]), .ns_yellow(lamps[4]), .ns_red(lamps[3]),
        .ew_green(lamps[2]), .ew_yellow(lamps[1]), .ew_red(lamps[0]),
        .fault_clr(fault_clr),
        .armed(armed), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // 0=green, 1=yellow, 2=red, 3=not one-hot
    function automatic int lamp_of(input logic [5:0] s, input bit ns);
        logic [2:0] b;
        b = ns ? s[5:3] : s[2:0];
        if (b == 3'b100) return 0;
        if (b == 3'b010) return 1;
        if (b == 3'b001) return 2;
        return 3;
    endfunction

    function automatic int dwell_at(input int j, input bit ns);
        int n;
        int st;
        n = 0;
        if (j < 0) return 0;
        st = lamp_of(hist[j], ns);
        for (int i = j; i >= 0; i--) begin
            if (lamp_of(hist[i], ns) != st) break;
            n++;
            if (i == arm_idx || n == 255) break;
        end
        return n;
    endfunction

    function automatic int allred_at(input int j);
        int n;
        n = 0;
        for (int i = j; i >= 0; i--) begin
            if (hist[i] != ALLRED) break;
            n++;
            if (n == 255) break;
        end
        return n;
    endfunction

    function automatic int unch_at(input int j);
        int n;
        logic [5:0] p;
        n = 0;
        for (int i = j; i >= 0; i--) begin
            if (i == arm_idx) begin
                n++;
                break;
            end
            p = (i == 0) ? ALLRED : hist[i-1];
            if (hist[i] != p) break;
            n++;
            if (n == 255) break;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int trans_viol(input int p, input int c, input int dwell, input int clear);
        if (p == c) return 0;
        if (p == 0 && c == 1) return (dwell < MIN_GREEN) ? 4 : 0;
        if (p == 1 && c == 2) return (dwell < MIN_YELLOW) ? 5 : 0;
        if (p == 2 && c == 0) return (clear < MIN_CLEAR) ? 6 : 0;
        return 3;
    endfunction

    function automatic int keep_min(input int a, input int b);
        if (a == 0) return b;
        if (b == 0) return a;
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        hist.delete();
        arm_idx = -1;
        m_armed = 1'b0;
        m_fault = 1'b0;
        m_code  = 3'd0;
    endtask

    task automatic model_step(input logic [5:0] s, input logic clr);
        logic [5:0] p;
        int j, ns_c, ew_c, code;
        p = (hist.size() == 0) ? ALLRED : hist[$];
        hist.push_back(s);
        j = hist.size() - 1;
        ns_c = lamp_of(s, 1);
        ew_c = lamp_of(s, 0);
        code = 0;
        if (ns_c != 2 && ew_c != 2)
            code = 1;
        else if (ns_c == 3 || ew_c == 3)
            code = 2;
        else if (m_armed) begin
            code = keep_min(code, trans_viol(lamp_of(p, 1), ns_c, dwell_at(j-1, 1), allred_at(j-1)));
            code = keep_min(code, trans_viol(lamp_of(p, 0), ew_c, dwell_at(j-1, 0), allred_at(j-1)));
            if (s == p && unch_at(j) == MAX_HOLD) code = keep_min(code, 7);
        end
        if (clr) begin
            m_armed = 1'b0;
            m_fault = (code == 1 || code == 2);
            m_code  = m_fault ? 3'(code) : 3'd0;
        end else if (!m_fault && code != 0) begin
            m_fault = 1'b1;
            m_code  = 3'(code);
            m_armed = 1'b0;
        end else if (!m_fault && !m_armed && s == ALLRED) begin
            m_armed = 1'b1;
            arm_idx = j;
        end
    endtask

    task automatic checkOutput(input string tag);
        n_checks++;
        assert (armed === m_armed) else begin
            n_fail++;
            $error("[TB] FAIL %s armed: observed %0b expected %0b", tag, armed, m_armed);
        end
        n_checks++;
        assert (fault === m_fault) else begin
            n_fail++;
            $error("[TB] FAIL %s fault: observed %0b expected %0b", tag, fault, m_fault);
        end
        n_checks++;
        assert (fault_code === m_code) else begin
            n_fail++;
            $error("[TB] FAIL %s fault_code: observed %0d expected %0d", tag, fault_code, m_code);
        end
    endtask

    task automatic expectConst(input string tag, input logic a, input logic f, input logic [2:0] c);
        n_checks++;
        assert (armed === a && fault === f && fault_code === c) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed armed=%0b fault=%0b code=%0d expected armed=%0b fault=%0b code=%0d",
                   tag, armed, fault, fault_code, a, f, c);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] s, input logic clr, input string tag);
        @(negedge clk);
        lamps = s;
        fault_clr = clr;
        model_step(s, clr);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic hold(input logic [5:0] s, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(s, 1'b0, tag);
    endtask

    task automatic randHold(input logic [5:0] s, input int n);
        logic [5:0] smp;
        logic       clr;
        for (int i = 0; i < n; i++) begin
            smp = s;
            if ($urandom_range(0, 39) == 0) smp = 6'($urandom);
            clr = ($urandom_range(0, 24) == 0);
            applyStimulus(smp, clr, "random");
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        lamps = ALLRED;
        fault_clr = 1'b0;
        model_reset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checkOutput(tag);
        expectConst(tag, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        lamps = ALLRED;
        fault_clr = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        checkOutput("power_on_reset");
        expectConst("power_on_reset", 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Legal cycles: arming on the first all-red, then no fault for three full cycles.
        applyStimulus(ALLRED, 1'b0, "legal_arm");
        expectConst("legal_arm", 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            hold(ALLRED, (k == 0) ? 6 : 7, "legal");
            hold(NSG, 60, "legal");
            hold(NSY, 4, "legal");
            hold(ALLRED, 7, "legal");
            hold(EWG, 60, "legal");
            hold(EWY, 4, "legal");
        end
        expectConst("legal_end", 1'b1, 1'b0, 3'd0);

        doReset();
        applyStimulus(6'b100_010, 1'b0, "conflict");
        expectConst("conflict", 1'b0, 1'b1, 3'd1);

        doReset();
        hold(ALLRED, 4, "short_yellow_setup");
        hold(NSG, 30, "short_yellow_setup");
        hold(NSY, 2, "short_yellow_setup");
        applyStimulus(ALLRED, 1'b0, "short_yellow");
        expectConst("short_yellow", 1'b0, 1'b1, 3'd5);
        applyStimulus(6'b100_100, 1'b0, "sticky_code");
        expectConst("sticky_code", 1'b0, 1'b1, 3'd5);

        doReset();
        hold(ALLRED, 4, "sequence_setup");
        hold(NSG, 30, "sequence_setup");
        applyStimulus(ALLRED, 1'b0, "sequence");
        expectConst("sequence", 1'b0, 1'b1, 3'd3);

        doReset();
        hold(ALLRED, 4, "encoding_setup");
        hold(NSG, 30, "encoding_setup");
        applyStimulus(6'b011_001, 1'b0, "encoding_wins");
        expectConst("encoding_wins", 1'b0, 1'b1, 3'd2);

        doReset();
        hold(ALLRED, 4, "short_clear_setup");
        hold(NSG, 30, "short_clear_setup");
        hold(NSY, 3, "short_clear_setup");
        hold(ALLRED, 3, "short_clear_setup");
        applyStimulus(EWG, 1'b0, "short_clear");
        expectConst("short_clear", 1'b0, 1'b1, 3'd6);
        applyStimulus(ALLRED, 1'b1, "fault_clr");
        expectConst("fault_clr", 1'b0, 1'b0, 3'd0);
        applyStimulus(ALLRED, 1'b0, "rearm");
        expectConst("rearm", 1'b1, 1'b0, 3'd0);

        doReset();
        hold(ALLRED, 4, "stuck_setup");
        hold(NSG, 99, "stuck_count");
        applyStimulus(NSG, 1'b0, "stuck_99");
        expectConst("stuck_99", 1'b1, 1'b0, 3'd0);
        applyStimulus(NSG, 1'b0, "stuck_100");
        expectConst("stuck_100", 1'b0, 1'b1, 3'd7);
        asyncReset("reset_after_fault");

        hold(ALLRED, 4, "midcount_setup");
        hold(NSG, 50, "midcount");
        asyncReset("reset_mid_count");

        // Randomized phases, occasional corrupt samples, long holds and fault releases.
        for (int seg = 0; seg < 30; seg++) begin
            randHold(ALLRED, $urandom_range(2, 6));
            randHold((seg % 2 == 0) ? NSG : EWG,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(95, 110) : $urandom_range(26, 40));
            randHold((seg % 2 == 0) ? NSY : EWY, $urandom_range(1, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
